// File: rtl/ad9361_spi_pkg.sv
// Shared constants and state type for the AD9361 SPI responder model.
package ad9361_spi_pkg;

  localparam int unsigned INSTR_BITS = 16;
  localparam int unsigned WR_BIT     = 15;
  localparam int unsigned NB_MSB     = 14;
  localparam int unsigned NB_LSB     = 12;
  localparam int unsigned ADDR_MSB   = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INSTR,
    S_WDATA,
    S_RDATA,
    S_HOLD
  } spi_state_e;

endpackage

// File: rtl/ad9361_spi_responder_pin_sync.sv
// Synchronizes the three SPI pins into clk and derives spi_clk / spi_enb edge pulses.
module spi_pin_sync #(
  parameter int unsigned SYNC_STG = 2
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic enb_i,
  input  logic sclk_i,
  input  logic di_i,
  output logic di_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic enb_fall_o,
  output logic enb_rise_o
);

  logic [SYNC_STG-1:0] enb_q, sclk_q, di_q;
  logic                enb_prev_q, sclk_prev_q;

  // Chains reset to 0 so a still-low enb at reset release never looks like a new select.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      enb_q       <= '0;
      sclk_q      <= '0;
      di_q        <= '0;
      enb_prev_q  <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      enb_q[0]  <= enb_i;
      sclk_q[0] <= sclk_i;
      di_q[0]   <= di_i;
      for (int unsigned i = 1; i < SYNC_STG; i++) begin
        enb_q[i]  <= enb_q[i-1];
        sclk_q[i] <= sclk_q[i-1];
        di_q[i]   <= di_q[i-1];
      end
      enb_prev_q  <= enb_q[SYNC_STG-1];
      sclk_prev_q <= sclk_q[SYNC_STG-1];
    end
  end

  assign di_o        = di_q[SYNC_STG-1];
  assign sclk_rise_o =  sclk_q[SYNC_STG-1] & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_q[SYNC_STG-1] &  sclk_prev_q;
  assign enb_rise_o  =  enb_q[SYNC_STG-1]  & ~enb_prev_q;
  assign enb_fall_o  = ~enb_q[SYNC_STG-1]  &  enb_prev_q;

endmodule

// File: rtl/ad9361_spi_responder.sv
// AD9361 register-port SPI responder: decodes instructions, services 1-8 byte reads/writes.
module ad9361_spi_responder
  import ad9361_spi_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned LSB_DLY  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_enb,
  input  logic              spi_clk,
  input  logic              spi_di,
  output logic              spi_do,
  output logic              spi_do_oe,
  input  logic [ADDR_W-1:0] loc_rd_addr,
  output logic [7:0]        loc_rd_data,
  output logic              wr_vld,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_vld,
  output logic              xfer_abort
);

  if (LSB_DLY != 0) begin : g_lsb_dly_chk
    $error("LSB_DLY must be 0: only MSB-first transfers are supported");
  end
  if (ADDR_W > ADDR_MSB + 1) begin : g_addr_w_chk
    $error("ADDR_W must not exceed the instruction address field");
  end

  logic di_s, sclk_rise, sclk_fall, enb_fall, enb_rise;

  spi_pin_sync #(.SYNC_STG(SYNC_STG)) u_pin_sync (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .enb_i       (spi_enb),
    .sclk_i      (spi_clk),
    .di_i        (spi_di),
    .di_o        (di_s),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .enb_fall_o  (enb_fall),
    .enb_rise_o  (enb_rise)
  );

  spi_state_e             state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [INSTR_BITS-2:0]  sh_q, sh_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [2:0]             nb_q, nb_d;
  logic [7:0]             dout_q, dout_d;
  logic                   do_q, do_d, oe_q, oe_d;
  logic                   wr_vld_q, wr_vld_d, rd_vld_q, rd_vld_d, abort_q, abort_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   we;
  logic [INSTR_BITS-1:0]  sh_next;
  logic [ADDR_W-1:0]      instr_addr, rd_ptr;
  logic [7:0]             mem_q [2**ADDR_W];
  logic                   unused_bits;

  assign sh_next     = {sh_q, di_s};
  assign instr_addr  = sh_next[ADDR_MSB -: ADDR_W];
  // Only the INSTR->RDATA load uses the fresh instruction address; later reloads use the next address down.
  assign rd_ptr      = (state_q == S_INSTR) ? instr_addr : addr_q - ADDR_W'(1);
  assign unused_bits = ^sh_next[ADDR_MSB+2:ADDR_MSB+1];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    nb_d      = nb_q;
    dout_d    = dout_q;
    do_d      = do_q;
    oe_d      = oe_q;
    wr_vld_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_vld_d  = 1'b0;
    abort_d   = 1'b0;
    we        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enb_fall) begin
          state_d   = S_INSTR;
          bit_cnt_d = '0;
        end
      end
      S_INSTR: begin
        if (enb_rise) begin
          state_d = S_IDLE;
          abort_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          sh_d      = sh_next[INSTR_BITS-2:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(INSTR_BITS - 1)) begin
            bit_cnt_d = '0;
            addr_d    = instr_addr;
            nb_d      = sh_next[NB_MSB:NB_LSB];
            if (sh_next[WR_BIT]) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_RDATA;
              dout_d  = mem_q[rd_ptr];
              oe_d    = 1'b1;
            end
          end
        end
      end
      S_WDATA: begin
        if (enb_rise) begin
          state_d = S_IDLE;
          abort_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          sh_d      = sh_next[INSTR_BITS-2:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            we        = 1'b1;
            wr_vld_d  = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = sh_next[7:0];
            addr_d    = addr_q - ADDR_W'(1);
            if (nb_q == '0) state_d = S_HOLD;
            else            nb_d    = nb_q - 3'd1;
          end
        end
      end
      S_RDATA: begin
        if (enb_rise) begin
          state_d = S_IDLE;
          abort_d = (bit_cnt_q != '0);
          oe_d    = 1'b0;
          do_d    = 1'b0;
        end else if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            rd_vld_d  = 1'b1;
            addr_d    = addr_q - ADDR_W'(1);
            if (nb_q == '0) begin
              state_d = S_HOLD;
              oe_d    = 1'b0;
              do_d    = 1'b0;
            end else begin
              nb_d   = nb_q - 3'd1;
              dout_d = mem_q[rd_ptr];
            end
          end
        end else if (sclk_fall) begin
          do_d   = dout_q[7];
          dout_d = {dout_q[6:0], 1'b0};
        end
      end
      S_HOLD: begin
        if (enb_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      addr_q    <= '0;
      nb_q      <= '0;
      dout_q    <= '0;
      do_q      <= 1'b0;
      oe_q      <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_vld_q  <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      nb_q      <= nb_d;
      dout_q    <= dout_d;
      do_q      <= do_d;
      oe_q      <= oe_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_vld_q  <= rd_vld_d;
      abort_q   <= abort_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[addr_q] <= sh_next[7:0];
  end

  assign loc_rd_data = mem_q[loc_rd_addr];
  assign spi_do      = do_q;
  assign spi_do_oe   = oe_q;
  assign wr_vld      = wr_vld_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_vld      = rd_vld_q;
  assign xfer_abort  = abort_q;

endmodule

// File: tb/tb_ad9361_spi_responder.sv
// Bench for ad9361_spi_responder: bit-banged SPI initiator against a byte-level register model.
module tb_ad9361_spi_responder;

  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst_n, spi_enb, spi_clk, spi_di, spi_do, spi_do_oe;
  logic [9:0] loc_rd_addr, wr_addr;
  logic [7:0] loc_rd_data, wr_data;
  logic       wr_vld, rd_vld, xfer_abort;

  ad9361_spi_responder #(.ADDR_W(10), .SYNC_STG(2), .LSB_DLY(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_enb     (spi_enb),
    .spi_clk     (spi_clk),
    .spi_di      (spi_di),
    .spi_do      (spi_do),
    .spi_do_oe   (spi_do_oe),
    .loc_rd_addr (loc_rd_addr),
    .loc_rd_data (loc_rd_data),
    .wr_vld      (wr_vld),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_vld      (rd_vld),
    .xfer_abort  (xfer_abort)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  mdl [1024];
  logic [17:0] wr_q[$];
  int          rd_cnt, abort_cnt;

  always @(negedge clk) begin
    if (wr_vld)     wr_q.push_back({wr_addr, wr_data});
    if (rd_vld)     rd_cnt++;
    if (xfer_abort) abort_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends nbits bits; reset is pulsed from bit rst_bit to rst_bit+2 when rst_bit >= 0.
  task automatic xfer(input logic [15:0] instr, input logic [63:0] wdata, input int nbits,
                      input int rst_bit, output logic [63:0] rdata,
                      output int oe_instr, output int oe_data);
    rdata = '0; oe_instr = 0; oe_data = 0;
    @(negedge clk); spi_enb = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      spi_di = (k < 16) ? instr[15-k] : wdata[63-(k-16)];
      if (rst_bit >= 0 && k == rst_bit)     rst_n = 1'b0;
      if (rst_bit >= 0 && k == rst_bit + 2) rst_n = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k < 16) oe_instr += int'(spi_do_oe);
      else begin
        oe_data += int'(spi_do_oe);
        rdata[63-(k-16)] = spi_do;
      end
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_enb = 1'b1; spi_di = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_txn(input string tag, input bit wr, input int nb, input logic [9:0] addr,
                        input logic [63:0] wdata, input int nbits);
    logic [15:0] instr;
    logic [63:0] rdata, exp_rd, mask;
    int          oe_i, oe_d, full, exp_abort;
    logic [9:0]  a;
    instr = {wr, 3'(nb - 1), 2'b00, addr};
    full = (nbits > 16) ? (nbits - 16) / 8 : 0;
    if (full > nb) full = nb;
    exp_abort = ((nbits > 0 && nbits < 16) || (nbits > 16 && (nbits - 16) % 8 != 0)) ? 1 : 0;
    exp_rd = '0; mask = '0;
    for (int i = 0; i < full; i++) begin
      a = addr - 10'(i);
      mask[63-8*i -: 8] = 8'hFF;
      exp_rd[63-8*i -: 8] = mdl[a];
    end
    wr_q.delete(); rd_cnt = 0; abort_cnt = 0;
    xfer(instr, wdata, nbits, -1, rdata, oe_i, oe_d);
    check({tag, " abort"}, 64'(abort_cnt), 64'(exp_abort));
    check({tag, " oe_instr"}, 64'(oe_i), 64'd0);
    check({tag, " oe_idle"}, 64'(spi_do_oe), 64'd0);
    if (wr) begin
      check({tag, " wr_cnt"}, 64'(wr_q.size()), 64'(full));
      check({tag, " rd_cnt"}, 64'(rd_cnt), 64'd0);
      for (int i = 0; i < full && i < wr_q.size(); i++)
        check({tag, " wr_evt"}, 64'(wr_q[i]), 64'({addr - 10'(i), wdata[63-8*i -: 8]}));
      for (int i = 0; i < full; i++) begin
        a = addr - 10'(i);
        mdl[a] = wdata[63-8*i -: 8];
      end
    end else begin
      check({tag, " wr_cnt"}, 64'(wr_q.size()), 64'd0);
      check({tag, " rd_cnt"}, 64'(rd_cnt), 64'(full));
      check({tag, " oe_data"}, 64'(oe_d), 64'((nbits > 16) ? nbits - 16 : 0));
      check({tag, " rdata"}, rdata & mask, exp_rd);
    end
  endtask

  task automatic loc_check(input string tag, input logic [9:0] a);
    loc_rd_addr = a;
    @(negedge clk);
    check(tag, 64'(loc_rd_data), 64'(mdl[a]));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rdata;
    int          oe_i, oe_d, nb, nb2, nbits;
    logic [9:0]  a;
    rst_n = 1'b0; spi_enb = 1'b1; spi_clk = 1'b0; spi_di = 1'b0; loc_rd_addr = '0;
    repeat (5) @(negedge clk);
    check("reset_outs", 64'({spi_do, spi_do_oe, wr_vld, rd_vld, xfer_abort}), 64'd0);
    check("reset_wr_bus", 64'({wr_addr, wr_data}), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    do_txn("wr1", 1, 1, 10'h005, {8'h3C, 56'h0}, 24);
    loc_check("loc_005", 10'h005);
    check("loc_005_val", 64'(loc_rd_data), 64'h3C);
    do_txn("rd1", 0, 1, 10'h005, '0, 24);

    do_txn("wr3", 1, 3, 10'h0FF, {24'h112233, 40'h0}, 40);
    do_txn("rd3", 0, 3, 10'h0FF, '0, 40);

    do_txn("wrap", 1, 3, 10'h001, {24'hA1B2C3, 40'h0}, 40);
    loc_check("loc_3ff", 10'h3FF);
    do_txn("wrap_rd", 0, 3, 10'h001, '0, 40);

    do_txn("abort12", 1, 1, 10'h010, {8'h5A, 56'h0}, 12);
    do_txn("post_abort", 1, 1, 10'h010, {8'h5A, 56'h0}, 24);
    loc_check("loc_010", 10'h010);
    do_txn("bound_wr", 1, 3, 10'h020, {24'hDEADBE, 40'h0}, 32);
    do_txn("bound_rd", 0, 2, 10'h020, '0, 24);

    // Reset in the 4th data bit of a read of 0x005.
    wr_q.delete(); rd_cnt = 0; abort_cnt = 0;
    xfer(16'h0005, '0, 24, 19, rdata, oe_i, oe_d);
    check("rst_oe_data", 64'(oe_d), 64'd3);
    check("rst_pulses", 64'(wr_q.size() + rd_cnt + abort_cnt), 64'd0);
    check("rst_oe_idle", 64'(spi_do_oe), 64'd0);
    do_txn("post_rst", 1, 1, 10'h001, {8'h77, 56'h0}, 24);
    loc_check("loc_001", 10'h001);

    for (int it = 0; it < 16; it++) begin
      a  = 10'($urandom);
      nb = $urandom_range(1, 8);
      do_txn("rnd_wr", 1, nb, a, {$urandom, $urandom}, 16 + 8 * nb);
      nb2   = $urandom_range(1, nb);
      nbits = 16 + 8 * nb2;
      if ($urandom_range(0, 3) == 0) nbits = $urandom_range(1, nbits - 1);
      do_txn("rnd_rd", 0, nb2, a, '0, nbits);
      if ($urandom_range(0, 3) == 0)
        do_txn("rnd_wab", 1, nb, 10'($urandom), {$urandom, $urandom}, $urandom_range(1, 16 + 8 * nb - 1));
      loc_check("rnd_loc", a);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
